// File: rtl/stream_switch_pkg.sv
// stream_switch_pkg: shared FSM state type and select-width helper for the stream path switch
package stream_switch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    function automatic int sel_width(input int num_eng);
        return (num_eng < 1) ? 1 : $clog2(num_eng + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: 2-entry skid buffer with registered input ready, carrying sop/eop with the data
module stream_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    input  logic              out_ready
);

    logic [DATA_W+1:0] out_q;
    logic [DATA_W+1:0] skid_q;
    logic              skid_valid;

    // Ready depends only on skid occupancy, so src_ready never reaches the upstream ready path
    assign in_ready = !skid_valid;
    assign {out_sop, out_eop, out_data} = out_q;

    // Refill the output stage from the skid entry first, otherwise park a stalled beat in the skid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid  <= skid_valid || in_valid;
            out_q      <= skid_valid ? skid_q : {in_sop, in_eop, in_data};
            skid_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            skid_q     <= {in_sop, in_eop, in_data};
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/stream_path_switch.sv
// stream_path_switch: routes whole packets through bypass or one of NUM_ENG engines into a skid-buffered source
module stream_path_switch
    import stream_switch_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  NUM_ENG = 2,
    parameter int  CNT_W   = 16,
    localparam int SEL_W   = sel_width(NUM_ENG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SEL_W-1:0]          path_sel,
    input  logic [DATA_W-1:0]         snk_data,
    input  logic                      snk_valid,
    input  logic                      snk_sop,
    input  logic                      snk_eop,
    output logic                      snk_ready,
    output logic [DATA_W-1:0]         src_data,
    output logic                      src_valid,
    output logic                      src_sop,
    output logic                      src_eop,
    input  logic                      src_ready,
    output logic [DATA_W-1:0]         eng_tx_data,
    output logic                      eng_tx_sop,
    output logic                      eng_tx_eop,
    output logic [NUM_ENG-1:0]        eng_tx_valid,
    input  logic [NUM_ENG-1:0]        eng_tx_ready,
    input  logic [NUM_ENG*DATA_W-1:0] eng_rx_data,
    input  logic [NUM_ENG-1:0]        eng_rx_valid,
    input  logic [NUM_ENG-1:0]        eng_rx_sop,
    input  logic [NUM_ENG-1:0]        eng_rx_eop,
    output logic [NUM_ENG-1:0]        eng_rx_ready,
    output logic [SEL_W-1:0]          active_path,
    output logic                      busy,
    output logic                      sel_err,
    output logic [CNT_W-1:0]          pkt_count,
    output logic [CNT_W-1:0]          drop_count
);

    state_t            state;
    state_t            state_nx;
    logic              sel_bad;
    logic [SEL_W-1:0]  sel_ok;
    logic [SEL_W-1:0]  route;
    logic              fwd;
    logic              path_ready;
    logic              snk_fire;
    logic              src_fire;
    logic [DATA_W-1:0] sl_in_data;
    logic              sl_in_valid;
    logic              sl_in_sop;
    logic              sl_in_eop;
    logic              sl_in_ready;

    // In IDLE the beat travels on the freshly loaded select; afterwards the locked path holds
    assign sel_bad = path_sel > SEL_W'(NUM_ENG);
    assign sel_ok  = sel_bad ? '0 : path_sel;
    assign route   = (state == IDLE) ? sel_ok : active_path;

    assign fwd       = !rst && snk_valid && (state == ACTIVE || (state == IDLE && snk_sop));
    assign snk_ready = (state == DRAIN) ? 1'b0 : (state == IDLE && !snk_sop) ? 1'b1 : path_ready;
    assign snk_fire  = snk_valid && snk_ready;
    assign src_fire  = src_valid && src_ready;
    assign busy      = state != IDLE;

    assign eng_tx_data = snk_data;
    assign eng_tx_sop  = snk_sop;
    assign eng_tx_eop  = snk_eop;

    // Steer the sink to bypass or engine k, and connect only the matching return lane to the output slice
    always_comb begin
        path_ready   = sl_in_ready;
        eng_tx_valid = '0;
        eng_rx_ready = '0;
        sl_in_valid  = fwd;
        sl_in_data   = snk_data;
        sl_in_sop    = snk_sop;
        sl_in_eop    = snk_eop;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (route == SEL_W'(i + 1)) begin
                path_ready      = eng_tx_ready[i];
                eng_tx_valid[i] = fwd;
                eng_rx_ready[i] = sl_in_ready;
                sl_in_valid     = eng_rx_valid[i];
                sl_in_data      = eng_rx_data[i*DATA_W +: DATA_W];
                sl_in_sop       = eng_rx_sop[i];
                sl_in_eop       = eng_rx_eop[i];
            end
        end
    end

    // Packet FSM: open on sop, close on sink eop, release once the packet's eop leaves the source port
    always_comb begin
        state_nx = (state == IDLE && snk_fire && snk_sop) ? (snk_eop ? DRAIN : ACTIVE)
                 : (state == ACTIVE && snk_fire && snk_eop) ? DRAIN
                 : (state == DRAIN && src_fire && src_eop) ? IDLE
                 : state;
    end

    // State, path lock, sticky select error and status counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_path <= '0;
            sel_err     <= 1'b0;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE)
                active_path <= sel_ok;
            if (state == IDLE && sel_bad)
                sel_err <= 1'b1;
            if (state == DRAIN && src_fire && src_eop)
                pkt_count <= pkt_count + CNT_W'(1);
            if (state == IDLE && snk_fire && !snk_sop && drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
        end
    end

    stream_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .in_data   (sl_in_data),
        .in_valid  (sl_in_valid),
        .in_sop    (sl_in_sop),
        .in_eop    (sl_in_eop),
        .in_ready  (sl_in_ready),
        .out_data  (src_data),
        .out_valid (src_valid),
        .out_sop   (src_sop),
        .out_eop   (src_eop),
        .out_ready (src_ready)
    );

endmodule

// File: tb/tb_stream_path_switch.sv
// tb_stream_path_switch: directed checks of bypass, engine routing, drain, backpressure, errors and reset
module tb_stream_path_switch;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  path_sel;
    logic [31:0] snk_data;
    logic        snk_valid, snk_sop, snk_eop, snk_ready;
    logic [31:0] src_data;
    logic        src_valid, src_sop, src_eop, src_ready;
    logic [31:0] eng_tx_data;
    logic        eng_tx_sop, eng_tx_eop;
    logic [1:0]  eng_tx_valid, eng_tx_ready;
    logic [63:0] eng_rx_data;
    logic [1:0]  eng_rx_valid, eng_rx_sop, eng_rx_eop, eng_rx_ready;
    logic [1:0]  active_path;
    logic        busy, sel_err;
    logic [15:0] pkt_count, drop_count;

    int          tests = 0;
    int          fails = 0;
    int          sent, got, tx_bad, rx0_bad;
    logic [33:0] q[$];
    logic [33:0] head;

    always #5 clk = ~clk;

    stream_path_switch #(.DATA_W(32), .NUM_ENG(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .path_sel(path_sel),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_ready(snk_ready),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop), .src_ready(src_ready),
        .eng_tx_data(eng_tx_data), .eng_tx_sop(eng_tx_sop), .eng_tx_eop(eng_tx_eop),
        .eng_tx_valid(eng_tx_valid), .eng_tx_ready(eng_tx_ready),
        .eng_rx_data(eng_rx_data), .eng_rx_valid(eng_rx_valid), .eng_rx_sop(eng_rx_sop), .eng_rx_eop(eng_rx_eop),
        .eng_rx_ready(eng_rx_ready),
        .active_path(active_path), .busy(busy), .sel_err(sel_err),
        .pkt_count(pkt_count), .drop_count(drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        snk_data  = d;
        snk_valid = 1'b1;
        snk_sop   = s;
        snk_eop   = e;
    endtask

    initial begin
        rst = 1'b1; path_sel = 2'd0; snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        src_ready = 1'b1; eng_tx_ready = 2'b11; eng_rx_data = '0; eng_rx_valid = '0; eng_rx_sop = '0; eng_rx_eop = '0;
        tick(); tick();
        chk("rst_src_valid", 64'(src_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_tx_valid", 64'(eng_tx_valid), 64'(0));
        chk("rst_counts", 64'({pkt_count, drop_count}), 64'(0));
        chk("rst_path_err", 64'({active_path, sel_err}), 64'(0));
        rst = 1'b0;
        tick();

        // bypass 4-beat packet
        for (int i = 0; i < 4; i++) begin
            beat(32'(32'h11 * (i + 1)), i == 0, i == 3);
            #1;
            chk("byp_snk_ready", 64'(snk_ready), 64'(1));
            if (i == 0) chk("byp_rx_ready", 64'(eng_rx_ready), 64'(0));
            tick();
            chk("byp_src", 64'({src_valid, src_sop, src_eop, src_data}),
                64'({1'b1, i == 0, i == 3, 32'(32'h11 * (i + 1))}));
            if (i == 0) chk("byp_busy", 64'(busy), 64'(1));
        end
        snk_valid = 1'b0;
        #1;
        chk("byp_drain_ready", 64'(snk_ready), 64'(0));
        tick();
        chk("byp_done", 64'({busy, src_valid, pkt_count}), 64'({1'b0, 1'b0, 16'd1}));

        // select change mid-packet stays on bypass
        for (int i = 0; i < 4; i++) begin
            if (i == 2) path_sel = 2'd1;
            beat(32'(32'hB0 + i), i == 0, i == 3);
            #1;
            if (i >= 2) chk("mid_tx_valid", 64'(eng_tx_valid), 64'(0));
            tick();
            chk("mid_src", 64'({src_valid, src_eop, src_data}), 64'({1'b1, i == 3, 32'(32'hB0 + i)}));
        end
        chk("mid_path", 64'(active_path), 64'(0));
        snk_valid = 1'b0;
        tick();
        chk("mid_pkt", 64'(pkt_count), 64'(2));

        // next packet to engine 0, then drain for a delayed engine eop
        beat(32'h55, 1'b1, 1'b1);
        #1;
        chk("eng_tx_valid", 64'(eng_tx_valid), 64'(2'b01));
        chk("eng_tx_bcast", 64'({eng_tx_sop, eng_tx_eop, eng_tx_data}), 64'({1'b1, 1'b1, 32'h55}));
        eng_tx_ready = 2'b10;
        #1;
        chk("eng_ready_low", 64'(snk_ready), 64'(0));
        eng_tx_ready = 2'b11;
        #1;
        chk("eng_ready_high", 64'(snk_ready), 64'(1));
        tick();
        chk("eng_lock", 64'({active_path, busy}), 64'({2'd1, 1'b1}));
        for (int i = 0; i < 4; i++) begin
            beat(32'hDEAD, 1'b1, 1'b0);
            #1;
            chk("drain_block", 64'({snk_ready, eng_tx_valid}), 64'(0));
            tick();
            chk("drain_src_idle", 64'(src_valid), 64'(0));
        end
        snk_valid = 1'b0;
        eng_rx_data = {32'h0, 32'hAA55}; eng_rx_valid = 2'b01; eng_rx_sop = 2'b01; eng_rx_eop = 2'b01;
        #1;
        chk("drain_rx_ready", 64'(eng_rx_ready), 64'(2'b01));
        tick();
        eng_rx_valid = 2'b00;
        chk("drain_src", 64'({src_valid, src_eop, src_data, busy}), 64'({1'b1, 1'b1, 32'hAA55, 1'b1}));
        tick();
        chk("drain_release", 64'({busy, pkt_count}), 64'({1'b0, 16'd3}));

        // 64-beat packet through engine 1 with random source backpressure
        path_sel = 2'd2;
        sent = 0; got = 0; tx_bad = 0; rx0_bad = 0;
        for (int cyc = 0; cyc < 1000 && got < 64; cyc++) begin
            snk_valid = sent < 64;
            snk_data  = 32'(32'h1000 + sent);
            snk_sop   = sent == 0;
            snk_eop   = sent == 63;
            head = (q.size() > 0) ? q[0] : '0;
            eng_rx_valid = {q.size() > 0, 1'b0};
            eng_rx_data  = {head[31:0], 32'h0};
            eng_rx_sop   = {head[33], 1'b0};
            eng_rx_eop   = {head[32], 1'b0};
            src_ready = 1'($urandom_range(0, 1));
            #1;
            if (eng_rx_valid[1] && eng_rx_ready[1]) void'(q.pop_front());
            if (snk_valid && snk_ready) begin
                if (eng_tx_valid != 2'b10) tx_bad++;
                q.push_back({snk_sop, snk_eop, snk_data});
                sent++;
            end
            if (eng_rx_ready[0]) rx0_bad++;
            if (src_valid && src_ready) begin
                chk("bp_beat", 64'({src_sop, src_eop, src_data}), 64'({got == 0, got == 63, 32'(32'h1000 + got)}));
                got++;
            end
            tick();
        end
        snk_valid = 1'b0; eng_rx_valid = 2'b00; src_ready = 1'b1;
        chk("bp_count", 64'(got), 64'(64));
        chk("bp_tx_valid", 64'(tx_bad), 64'(0));
        chk("bp_rx0_ready", 64'(rx0_bad), 64'(0));
        chk("bp_done", 64'({busy, pkt_count}), 64'({1'b0, 16'd4}));

        // orphan beats and invalid select
        path_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin
            beat(32'(32'hE0 + i), 1'b0, 1'b0);
            #1;
            chk("drop_ready", 64'(snk_ready), 64'(1));
            tick();
            chk("drop_no_fwd", 64'({src_valid, busy}), 64'(0));
        end
        snk_valid = 1'b0;
        chk("drop_count", 64'(drop_count), 64'(3));
        path_sel = 2'd2;
        tick();
        chk("sel_ok", 64'({active_path, sel_err}), 64'({2'd2, 1'b0}));
        path_sel = 2'd3;
        tick();
        chk("sel_bad", 64'({active_path, sel_err}), 64'({2'd0, 1'b1}));

        // reset mid-packet
        path_sel = 2'd0;
        beat(32'h61, 1'b1, 1'b0);
        tick();
        beat(32'h62, 1'b0, 1'b0);
        tick();
        chk("rm_busy", 64'(busy), 64'(1));
        snk_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rm_state", 64'({src_valid, busy, sel_err, eng_tx_valid}), 64'(0));
        chk("rm_counts", 64'({pkt_count, drop_count}), 64'(0));
        rst = 1'b0;
        beat(32'h63, 1'b0, 1'b1);
        tick();
        chk("rm_orphan", 64'({src_valid, busy, drop_count}), 64'({1'b0, 1'b0, 16'd1}));
        beat(32'h70, 1'b1, 1'b1);
        tick();
        snk_valid = 1'b0;
        chk("rm_new_pkt", 64'({src_valid, src_sop, src_eop, src_data}), 64'({1'b1, 1'b1, 1'b1, 32'h70}));
        tick();
        chk("rm_pkt_count", 64'({busy, pkt_count}), 64'({1'b0, 16'd1}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_path_switch.md
STREAM_PATH_SWITCH -- requirements
Module: stream_path_switch

Interface
REQ-001 Parameter DATA_W, default 32: streaming data width in bits.
REQ-002 Parameter NUM_ENG, default 2: number of processing engines; paths are 0 = bypass and 1..NUM_ENG = engine k-1.
REQ-003 Parameter CNT_W, default 16: width of the status counters.
REQ-004 Localparam SEL_W = max(1, clog2(NUM_ENG+1)).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 path_sel  in  SEL_W  requested path (CSR-driven).
REQ-009 snk_data/snk_valid/snk_sop/snk_eop  in  DATA_W/1/1/1  upstream sink beat; snk_ready  out  1.
REQ-010 src_data/src_valid/src_sop/src_eop  out  DATA_W/1/1/1  downstream source beat; src_ready  in  1.
REQ-011 eng_tx_data/eng_tx_sop/eng_tx_eop  out  DATA_W/1/1  broadcast to engines; eng_tx_valid  out  NUM_ENG; eng_tx_ready  in  NUM_ENG.
REQ-012 eng_rx_data  in  NUM_ENG*DATA_W  packed engine results; eng_rx_valid/eng_rx_sop/eng_rx_eop  in  NUM_ENG each; eng_rx_ready  out  NUM_ENG.
REQ-013 active_path  out  SEL_W  locked path; busy  out  1  state != IDLE; sel_err  out  1  sticky invalid-select flag.
REQ-014 pkt_count  out  CNT_W  completed packets; drop_count  out  CNT_W  dropped orphan beats.

Function
REQ-015 FSM states IDLE, ACTIVE, DRAIN; transitions occur only on handshakes (valid and ready both high).
REQ-016 IDLE: active_path loads path_sel every cycle; a path_sel value > NUM_ENG loads 0 and sets sel_err.
REQ-017 IDLE: a sink beat with sop and not eop moves to ACTIVE; a beat with sop and eop moves to DRAIN; the beat is forwarded on the newly loaded path.
REQ-018 IDLE: a sink beat without sop is accepted (snk_ready=1), discarded, and increments drop_count, which saturates at all-ones.
REQ-019 ACTIVE: path_sel changes are ignored; an accepted beat with eop moves to DRAIN.
REQ-020 DRAIN: snk_ready=0; a src handshake with src_eop=1 moves to IDLE and increments pkt_count, which wraps modulo 2^CNT_W.
REQ-021 Bypass path (0): sink beats go directly into the output slice; snk_ready equals the slice's input ready.
REQ-022 Engine path k: eng_tx_valid[k-1] = snk_valid gated by state; snk_ready = eng_tx_ready[k-1]; all other eng_tx_valid bits are 0.
REQ-023 Engine path k: the output slice accepts only eng_rx lane k-1; eng_rx_ready for every other lane is 0.
REQ-024 Output slice: 2-entry skid buffer; data/sop/eop are registered; latency is 1 cycle from the input handshake to src_valid.
REQ-025 Output slice: its input ready is registered (not combinational from src_ready); src_ready low for any duration loses or duplicates no beat; throughput is 1 beat/cycle when src_ready=1.
REQ-026 Simultaneous events: an eop accepted at the sink in the same cycle as a src eop from a previous packet does not occur by construction (DRAIN blocks the sink); no other ordering is required.
REQ-027 The eng_tx_* data, sop and eop outputs equal snk_data, snk_sop and snk_eop combinationally.

Reset
REQ-028 When rst=1 at a clock edge: the FSM enters IDLE; active_path, sel_err, pkt_count and drop_count clear to 0; both skid entries are invalidated.
REQ-029 During and after reset: src_valid=0, eng_tx_valid=0, busy=0; snk_ready and eng_rx_ready follow the IDLE rules in the cycle after reset deasserts.
REQ-030 Reset asserted mid-packet discards the in-flight beats; the next packet requires a fresh sop.

Structure
REQ-031 Package stream_switch_pkg holds the state enum (IDLE/ACTIVE/DRAIN) and the SEL_W computation function.
REQ-032 Sub-module stream_skid_buffer (parameter DATA_W, carries sop/eop) implements the output slice.

Verification
REQ-033 Bypass: path_sel=0; send a 4-beat packet 0x11..0x44 with src_ready=1 -> identical beats appear 1 cycle later; pkt_count=1.
REQ-034 Mid-packet select: path_sel=0; change to 1 after beat 2 -> the rest of the packet stays on bypass; the next packet goes to engine 0 (eng_tx_valid=2'b01).
REQ-035 Drain: engine 0 returns eop 5 cycles after sink eop -> snk_ready=0 for those cycles; busy drops the cycle after the src eop handshake.
REQ-036 Backpressure: random src_ready at 50% over a 64-beat packet on path 2 -> in-order, lossless output; eng_rx_ready[0]=0 throughout.
REQ-037 Errors: 3 beats without sop in IDLE -> drop_count=3, nothing forwarded; path_sel=3 with NUM_ENG=2 -> active_path=0 and sel_err=1.
REQ-038 Reset mid-packet: rst pulsed after beat 2 -> src_valid=0 and counters=0; a new sop packet passes normally.
